lm_sm_seq: RTL and testbench

//  Multi-cycle sequencer for the Load-Multiple / Store-Multiple instructions.

---
 rtl/lm_sm_seq.sv | 210 +++++++++++++++++++++
 tb/tb_lm_sm_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_seq.sv
// Load-Multiple / Store-Multiple sequencer: walks a register mask lowest-first, one memory access per register.
// Optional base-register writeback stage enabled by defining LMSM_WRITEBACK_EN.
module lm_sm_seq #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned NREG   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [NREG-1:0]   reg_mask,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              mem_ack,
`ifdef LMSM_WRITEBACK_EN
    input  logic [2:0]        base_reg,
    output logic [ADDR_W-1:0] wb_data,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [2:0]        reg_addr,
    output logic              reg_write,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      REG_W  = 3;
    localparam logic [REG_W-1:0] PC_IDX = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
`ifdef LMSM_WRITEBACK_EN
        S_WB   = 2'd3,
`endif
        S_DONE = 2'd2
    } state_t;

    // State entered once the mask is exhausted.
`ifdef LMSM_WRITEBACK_EN
    localparam state_t S_FINISH = S_WB;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    // Lowest set bit of a mask (0 when the mask is empty).
    function automatic logic [REG_W-1:0] lowest_idx(input logic [NREG-1:0] m);
        logic [REG_W-1:0] r;
        r = '0;
        for (int i = int'(NREG) - 1; i >= 0; i--) begin
            if (m[i]) r = REG_W'(i);
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [NREG-1:0]   rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              op_q, op_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [REG_W-1:0]  reg_addr_q, reg_addr_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wr_cand_q, wr_cand_d;

`ifdef LMSM_WRITEBACK_EN
    logic [REG_W-1:0]  base_reg_q, base_reg_d;
    logic              wb_wr_q, wb_wr_d;
    logic [ADDR_W-1:0] wb_data_q, wb_data_d;
`endif

    logic [REG_W-1:0]  cur_idx;
    logic [REG_W-1:0]  nxt_idx;

    // Next-state, latched operands and next registered outputs.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        op_d       = op_q;
        cur_idx    = lowest_idx(rem_q);
        nxt_idx    = '0;
        mem_addr_d = '0;
        reg_addr_d = '0;
        mem_re_d   = 1'b0;
        mem_we_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        wr_cand_d  = 1'b0;
`ifdef LMSM_WRITEBACK_EN
        base_reg_d = base_reg_q;
        wb_wr_d    = 1'b0;
        wb_data_d  = '0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d  = reg_mask;
                    addr_d = base_addr;
                    op_d   = is_store;
`ifdef LMSM_WRITEBACK_EN
                    base_reg_d = base_reg;
`endif
                    state_d = (reg_mask != '0) ? S_XFER : S_FINISH;
                end
            end
            S_XFER: begin
                if (mem_ack) begin
                    rem_d  = rem_q & ~(NREG'(1) << cur_idx);
                    addr_d = addr_q + ADDR_W'(1);
                    if (rem_d == '0) state_d = S_FINISH;
                end
            end
`ifdef LMSM_WRITEBACK_EN
            S_WB: begin
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered: decode what the next cycle presents.
        nxt_idx = lowest_idx(rem_d);
        unique case (state_d)
            S_XFER: begin
                mem_addr_d = addr_d;
                reg_addr_d = nxt_idx;
                mem_re_d   = ~op_d;
                mem_we_d   = op_d;
                busy_d     = 1'b1;
                wr_cand_d  = ~op_d & (nxt_idx != PC_IDX);
            end
`ifdef LMSM_WRITEBACK_EN
            S_WB: begin
                reg_addr_d = base_reg_d;
                busy_d     = 1'b1;
                wb_wr_d    = (base_reg_d != PC_IDX);
                wb_data_d  = addr_d;
            end
`endif
            S_DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            addr_q     <= '0;
            op_q       <= 1'b0;
            mem_addr_q <= '0;
            reg_addr_q <= '0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_cand_q  <= 1'b0;
`ifdef LMSM_WRITEBACK_EN
            base_reg_q <= '0;
            wb_wr_q    <= 1'b0;
            wb_data_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            mem_addr_q <= mem_addr_d;
            reg_addr_q <= reg_addr_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_cand_q  <= wr_cand_d;
`ifdef LMSM_WRITEBACK_EN
            base_reg_q <= base_reg_d;
            wb_wr_q    <= wb_wr_d;
            wb_data_q  <= wb_data_d;
`endif
        end
    end

    assign mem_addr = mem_addr_q;
    assign reg_addr = reg_addr_q;
    assign mem_re   = mem_re_q;
    assign mem_we   = mem_we_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // LM register write lands in the same cycle the memory returns data.
`ifdef LMSM_WRITEBACK_EN
    assign reg_write = (wr_cand_q & mem_ack) | wb_wr_q;
    assign wb_data   = wb_data_q;
`else
    assign reg_write = wr_cand_q & mem_ack;
`endif

endmodule

// File: tb/tb_lm_sm_seq.sv
// Scoreboard bench for lm_sm_seq: stimulus pushes expected accesses/done events, a monitor pops and compares.
module tb_lm_sm_seq;

`ifdef LMSM_WRITEBACK_EN
    localparam int WBX = 1;
`else
    localparam int WBX = 0;
`endif

    typedef struct packed {
        logic [1:0]  kind;   // 0 access, 1 writeback, 2 done
        logic        we;
        logic [15:0] addr;
        logic [2:0]  rg;
        logic        wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [7:0]  reg_mask = 8'h00;
    logic [15:0] base_addr = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_re, mem_we, reg_write, busy, done;
    logic [2:0]  reg_addr;
`ifdef LMSM_WRITEBACK_EN
    logic [2:0]  base_reg = 3'd0;
    logic [15:0] wb_data;
`endif

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   ack_delay = 0;

    lm_sm_seq #(.ADDR_W(16), .NREG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_store  (is_store),
        .reg_mask  (reg_mask),
        .base_addr (base_addr),
        .mem_ack   (mem_ack),
`ifdef LMSM_WRITEBACK_EN
        .base_reg  (base_reg),
        .wb_data   (wb_data),
`endif
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .reg_addr  (reg_addr),
        .reg_write (reg_write),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_acc(input logic we, input logic [15:0] a, input logic [2:0] r, input logic w);
        exp_q.push_back('{kind: 2'd0, we: we, addr: a, rg: r, wr: w});
    endtask

    task automatic push_wb(input logic [15:0] a, input logic [2:0] r, input logic w);
        if (WBX != 0) exp_q.push_back('{kind: 2'd1, we: 1'b0, addr: a, rg: r, wr: w});
    endtask

    task automatic push_done();
        exp_q.push_back('{kind: 2'd2, we: 1'b0, addr: 16'h0000, rg: 3'd0, wr: 1'b0});
    endtask

    // Memory model: acknowledges each access after ack_delay wait cycles.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (mem_re || mem_we) begin
                if (cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: classify each cycle's DUT activity and compare with the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) begin
                    if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("done_event", {8'd0, 2'd2, mem_re, mem_we, mem_addr, reg_addr, busy},
                            {8'd0, e.kind, 2'b00, 16'h0000, 3'd0, 1'b0});
                    end
                end else if ((mem_re || mem_we) && mem_ack) begin
                    if (exp_q.size() == 0) chk("unexpected_access", {16'd0, mem_addr}, 32'hDEAD);
                    else begin
                        e = exp_q.pop_front();
                        chk("access", {8'd0, 2'd0, mem_re, mem_we, mem_addr, reg_addr, reg_write},
                            {8'd0, e.kind, ~e.we, e.we, e.addr, e.rg, e.wr});
                    end
                end else if (mem_re || mem_we) begin
                    if (exp_q.size() == 0) chk("unexpected_strobe", {16'd0, mem_addr}, 32'hDEAD);
                    else begin
                        e = exp_q[0];
                        chk("hold", {8'd0, 2'd0, mem_re, mem_we, mem_addr, reg_addr, reg_write},
                            {8'd0, e.kind, ~e.we, e.we, e.addr, e.rg, 1'b0});
                    end
`ifdef LMSM_WRITEBACK_EN
                end else if (busy) begin
                    if (exp_q.size() == 0) chk("unexpected_wb", {16'd0, wb_data}, 32'hDEAD);
                    else begin
                        e = exp_q.pop_front();
                        chk("writeback", {8'd0, 2'd1, mem_re, mem_we, wb_data, reg_addr, reg_write},
                            {8'd0, e.kind, 2'b00, e.addr, e.rg, e.wr});
                    end
`endif
                end else begin
                    chk("idle_outs", {8'd0, busy, mem_re, mem_we, mem_addr, reg_addr, reg_write}, 32'd0);
                end
            end
        end
    end

    task automatic start_op(input logic st, input logic [7:0] mask, input logic [15:0] base,
                            input logic [2:0] breg);
        start     = 1'b1;
        is_store  = st;
        reg_mask  = mask;
        base_addr = base;
`ifdef LMSM_WRITEBACK_EN
        base_reg  = breg;
`else
        if (breg != 3'd0) $display("note: base_reg %0d unused in this build", breg);
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done starting at cycle cyc0; check latency, pulse width, optional start-in-DONE.
    task automatic wait_done(input string name, input int cyc0, input int lat, input bit poke);
        int cyc;
        cyc = cyc0;
        while (!done && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({name, "_done"}, {31'd0, done}, 32'd1);
        chk({name, "_latency"}, 32'(cyc), 32'(lat));
        if (poke) begin
            start = 1'b1; is_store = 1'b1; reg_mask = 8'h01; base_addr = 16'h0900;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, "_pulse1"}, {31'd0, done}, 32'd0);
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {24'd0, busy, done, mem_re, mem_we, reg_write, reg_addr}, 32'd0);
        chk("reset_addr", {16'd0, mem_addr}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: LM mask 0x05 from 0x0040, ack tied high
        ack_delay = 0;
        push_acc(1'b0, 16'h0040, 3'd0, 1'b1);
        push_acc(1'b0, 16'h0041, 3'd2, 1'b1);
        push_wb(16'h0042, 3'd0, 1'b1);
        push_done();
        start_op(1'b0, 8'h05, 16'h0040, 3'd0);
        chk("t1_c1", {11'd0, mem_re, busy, mem_addr, reg_addr, mem_we}, {11'd0, 1'b1, 1'b1, 16'h0040, 3'd0, 1'b0});
        wait_done("t1", 1, 3 + WBX, 1'b0);
        drain("t1");

        // 2: SM mask 0x81 from 0x0100, two wait cycles per access
        ack_delay = 2;
        push_acc(1'b1, 16'h0100, 3'd0, 1'b0);
        push_acc(1'b1, 16'h0101, 3'd7, 1'b0);
        push_wb(16'h0102, 3'd0, 1'b1);
        push_done();
        start_op(1'b1, 8'h81, 16'h0100, 3'd0);
        wait_done("t2", 1, 7 + WBX, 1'b0);
        drain("t2");
        ack_delay = 0;

        // 3: LM of R7 only at top of address space
        push_acc(1'b0, 16'hFFFF, 3'd7, 1'b0);
        push_wb(16'h0000, 3'd0, 1'b1);
        push_done();
        start_op(1'b0, 8'h80, 16'hFFFF, 3'd0);
        wait_done("t3", 1, 2 + WBX, 1'b0);
        drain("t3");

        // 4a: empty mask, with a start issued in the DONE cycle
        push_wb(16'h0200, 3'd0, 1'b1);
        push_done();
        start_op(1'b0, 8'h00, 16'h0200, 3'd0);
        wait_done("t4a", 1, 1 + WBX, 1'b1);
        drain("t4a");

        // 4b: LM mask 0xFF with an extra start while busy
        for (int i = 0; i < 8; i++) push_acc(1'b0, 16'h0300 + 16'(i), 3'(i), (i != 7));
        push_wb(16'h0308, 3'd0, 1'b1);
        push_done();
        start_op(1'b0, 8'hFF, 16'h0300, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; is_store = 1'b1; reg_mask = 8'h01; base_addr = 16'h0900;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t4b", 4, 9 + WBX, 1'b0);
        drain("t4b");

        // 5: reset asserted in cycle 4 of an LM mask 0xFF
        for (int i = 0; i < 3; i++) push_acc(1'b0, 16'h0400 + 16'(i), 3'(i), 1'b1);
        start_op(1'b0, 8'hFF, 16'h0400, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_outs", {24'd0, busy, done, mem_re, mem_we, reg_write, reg_addr}, 32'd0);
        chk("t5_async_addr", {16'd0, mem_addr}, 32'd0);
        chk("t5_partial", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_acc(1'b0, 16'h0500, 3'd1, 1'b1);
        push_acc(1'b0, 16'h0501, 3'd2, 1'b1);
        push_wb(16'h0502, 3'd0, 1'b1);
        push_done();
        start_op(1'b0, 8'h06, 16'h0500, 3'd0);
        wait_done("t5_restart", 1, 3 + WBX, 1'b0);
        drain("t5");

`ifdef LMSM_WRITEBACK_EN
        // 6: LM mask 0x0E with base register writeback to R5
        push_acc(1'b0, 16'h0010, 3'd1, 1'b1);
        push_acc(1'b0, 16'h0011, 3'd2, 1'b1);
        push_acc(1'b0, 16'h0012, 3'd3, 1'b1);
        push_wb(16'h0013, 3'd5, 1'b1);
        push_done();
        start_op(1'b0, 8'h0E, 16'h0010, 3'd5);
        wait_done("t6", 1, 5, 1'b0);
        drain("t6");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
